// File: rtl/odd_result_pipe_pkg.sv
// Shared constants, stage-entry type and latency helper for the odd result pipe.
package odd_result_pipe_pkg;

    localparam int ODD_RESULT_DEPTH = 7;
    localparam int RT_W             = 7;
    localparam int VALUE_W          = 128;
    localparam int LAT_W            = 3;
    localparam int NUM_SRC          = 3;

    typedef struct packed {
        logic               valid;
        logic [RT_W-1:0]    rt_address;
        logic [VALUE_W-1:0] value;
        logic [LAT_W-1:0]   latency;
    } odd_result_entry_t;

    // Latency 0 behaves as 1 and anything past the last stage completes there.
    function automatic logic [LAT_W-1:0] norm_latency(input logic [LAT_W-1:0] lat,
                                                      input int depth);
        if (lat == '0)
            return LAT_W'(1);
        if (int'(lat) > depth)
            return LAT_W'(depth);
        return lat;
    endfunction

endpackage

// File: rtl/odd_result_pipe_fwd_match_unit.sv
// Single-source forward lookup: youngest matching stage wins; reports hit or pending.
module fwd_match_unit
    import odd_result_pipe_pkg::*;
#(
    parameter int DEPTH = ODD_RESULT_DEPTH
) (
    input  logic                          check,
    input  logic [RT_W-1:0]               address,
    input  odd_result_entry_t [DEPTH:1]   stages,
    output logic                          hit,
    output logic [VALUE_W-1:0]            value,
    output logic                          pending
);

    // Walk oldest to youngest so the lowest matching stage is the last assignment.
    always_comb begin
        hit     = 1'b0;
        value   = '0;
        pending = 1'b0;
        if (check) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (stages[k].valid && stages[k].rt_address == address) begin
                    if (k >= int'(stages[k].latency)) begin
                        hit     = 1'b1;
                        value   = stages[k].value;
                        pending = 1'b0;
                    end else begin
                        hit     = 1'b0;
                        value   = '0;
                        pending = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/odd_result_pipe.sv
// Odd-pipe result staging: fixed-depth writeback, 3-source forwarding and stall detect.
// Optional stats counters are built when ODD_RESULT_FWD_STATS_EN is defined.
module odd_result_pipe
    import odd_result_pipe_pkg::*;
#(
    parameter int DEPTH        = ODD_RESULT_DEPTH,
    parameter int FLUSH_STAGES = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [RT_W-1:0]                   in_rt_address,
    input  logic [VALUE_W-1:0]                in_value,
    input  logic [LAT_W-1:0]                  in_latency,
    input  logic                              flush,
    input  logic [NUM_SRC-1:0][RT_W-1:0]      src_address,
    input  logic [NUM_SRC-1:0]                src_check,
    output logic [NUM_SRC-1:0]                fwd_hit,
    output logic [NUM_SRC-1:0][VALUE_W-1:0]   fwd_value,
    output logic                              stall,
    output logic                              wb_en,
    output logic [RT_W-1:0]                   wb_rt_address,
    output logic [VALUE_W-1:0]                wb_value
`ifdef ODD_RESULT_FWD_STATS_EN
    ,
    output logic [31:0]                       stat_fwd_count,
    output logic [31:0]                       stat_stall_count
`endif
);

    odd_result_entry_t [DEPTH:1] stage;
    odd_result_entry_t [DEPTH:1] shift_src;
    odd_result_entry_t           entry_in;
    logic [NUM_SRC-1:0]          pending;

    always_comb begin
        entry_in = '0;
        if (in_valid) begin
            entry_in.valid      = 1'b1;
            entry_in.rt_address = in_rt_address;
            entry_in.value      = in_value;
            entry_in.latency    = norm_latency(in_latency, DEPTH);
        end
    end

    always_comb begin
        shift_src    = '0;
        shift_src[1] = entry_in;
        for (int k = 2; k <= DEPTH; k++)
            shift_src[k] = stage[k-1];
    end

    // Flush squashes whatever lands in the youngest stages this edge, input included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++)
                stage[k] <= (flush && k <= FLUSH_STAGES) ? '0 : shift_src[k];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match_unit #(.DEPTH(DEPTH)) u_match (
            .check   (src_check[i]),
            .address (src_address[i]),
            .stages  (stage),
            .hit     (fwd_hit[i]),
            .value   (fwd_value[i]),
            .pending (pending[i])
        );
    end

    assign stall         = |pending;
    assign wb_en         = stage[DEPTH].valid;
    assign wb_rt_address = stage[DEPTH].valid ? stage[DEPTH].rt_address : '0;
    assign wb_value      = stage[DEPTH].valid ? stage[DEPTH].value : '0;

`ifdef ODD_RESULT_FWD_STATS_EN
    logic [32:0] fwd_sum;

    always_comb fwd_sum = {1'b0, stat_fwd_count} + 33'($countones(fwd_hit));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_fwd_count   <= '0;
            stat_stall_count <= '0;
        end else begin
            stat_fwd_count <= fwd_sum[32] ? '1 : fwd_sum[31:0];
            if (stall && stat_stall_count != '1)
                stat_stall_count <= stat_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_odd_result_pipe.sv
// Directed self-checking bench for odd_result_pipe (stats checks when ODD_RESULT_FWD_STATS_EN).
module tb_odd_result_pipe;

    localparam int DEPTH = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [6:0]        in_rt_address;
    logic [127:0]      in_value;
    logic [2:0]        in_latency;
    logic              flush;
    logic [2:0][6:0]   src_address;
    logic [2:0]        src_check;
    logic [2:0]        fwd_hit;
    logic [2:0][127:0] fwd_value;
    logic              stall;
    logic              wb_en;
    logic [6:0]        wb_rt_address;
    logic [127:0]      wb_value;
`ifdef ODD_RESULT_FWD_STATS_EN
    logic [31:0]       stat_fwd_count;
    logic [31:0]       stat_stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    odd_result_pipe #(.DEPTH(DEPTH), .FLUSH_STAGES(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_rt_address (in_rt_address),
        .in_value      (in_value),
        .in_latency    (in_latency),
        .flush         (flush),
        .src_address   (src_address),
        .src_check     (src_check),
        .fwd_hit       (fwd_hit),
        .fwd_value     (fwd_value),
        .stall         (stall),
        .wb_en         (wb_en),
        .wb_rt_address (wb_rt_address),
        .wb_value      (wb_value)
`ifdef ODD_RESULT_FWD_STATS_EN
        ,
        .stat_fwd_count   (stat_fwd_count),
        .stat_stall_count (stat_stall_count)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_rt_address = '0;
        in_value      = '0;
        in_latency    = '0;
        flush         = 1'b0;
        src_address   = '0;
        src_check     = '0;
    endtask

    task automatic push(input logic [6:0] rt, input logic [127:0] v, input logic [2:0] lat);
        in_valid      = 1'b1;
        in_rt_address = rt;
        in_value      = v;
        in_latency    = lat;
    endtask

    // Called just after an edge; the reset pulse ends well before the next one.
    task automatic clear_pipe();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int bad;
        n_checks++;
        if (wb_en !== 1'b0 || stall !== 1'b0 || fwd_hit !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: wb_en=%b stall=%b fwd_hit=%b, expected all 0", wb_en, stall, fwd_hit);
        end
`ifdef ODD_RESULT_FWD_STATS_EN
        n_checks++;
        if (stat_fwd_count !== 32'd0 || stat_stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: fwd=%0d stall=%0d, expected 0 0", stat_fwd_count, stat_stall_count);
        end
`endif
        push(7'd5, 128'hAA, 3'd1);
        repeat (3) tick();
        src_address[0] = 7'd5;
        src_check      = 3'b001;
        #1;
        n_checks++;
        if (fwd_hit !== 3'b001 || fwd_value[0] !== 128'hAA) begin
            n_fail++;
            $display("FAIL pre_reset_fwd: hit=%b value=%h, expected 001 aa", fwd_hit, fwd_value[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || stall !== 1'b0 || fwd_hit !== 3'b000 || fwd_value[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL async_reset: wb_en=%b stall=%b hit=%b value=%h, expected all 0",
                     wb_en, stall, fwd_hit, fwd_value[0]);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        bad = 0;
        repeat (DEPTH + 2) begin
            tick();
            if (wb_en !== 1'b0 || fwd_hit !== 3'b000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_empty: %0d cycles showed activity, expected 0", bad);
        end
    endtask

    task automatic test_fixed_wb();
        clear_pipe();
        push(7'd12, 128'd20, 3'd4);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) idle();
            n_checks++;
            if (wb_en !== (c == 7)) begin
                n_fail++;
                $display("FAIL fixed_wb_en cycle %0d: wb_en=%b expected %b", c, wb_en, (c == 7));
            end
            if (c == 7) begin
                n_checks++;
                if (wb_rt_address !== 7'd12 || wb_value !== 128'd20) begin
                    n_fail++;
                    $display("FAIL fixed_wb_data: rt=%0d value=%0d expected 12 20", wb_rt_address, wb_value);
                end
            end else begin
                n_checks++;
                if (wb_rt_address !== 7'd0 || wb_value !== 128'd0) begin
                    n_fail++;
                    $display("FAIL fixed_wb_idle cycle %0d: rt=%0d value=%0d expected 0 0", c, wb_rt_address, wb_value);
                end
            end
        end
    endtask

    task automatic test_stall_forward();
        clear_pipe();
        push(7'd3, 128'h33, 3'd4);
        src_address[0] = 7'd3;
        src_address[2] = 7'd3;
        src_check      = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            in_valid = 1'b0;
            if (c < 4) begin
                n_checks++;
                if (stall !== 1'b1 || fwd_hit !== 3'b000) begin
                    n_fail++;
                    $display("FAIL stall_pending cycle %0d: stall=%b hit=%b expected 1 000", c, stall, fwd_hit);
                end
            end
        end
        n_checks++;
        if (stall !== 1'b0 || fwd_hit !== 3'b001 || fwd_value[0] !== 128'h33) begin
            n_fail++;
            $display("FAIL forward_complete: stall=%b hit=%b value=%h expected 0 001 33", stall, fwd_hit, fwd_value[0]);
        end
        n_checks++;
        if (fwd_value[2] !== 128'd0) begin
            n_fail++;
            $display("FAIL unchecked_src_value: value=%h expected 0", fwd_value[2]);
        end
        src_check = 3'b000;
        #1;
        n_checks++;
        if (fwd_hit !== 3'b000 || fwd_value[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL check_disabled: hit=%b value=%h expected 000 0", fwd_hit, fwd_value[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_pipe();
        push(7'd9, 128'd1, 3'd1);
        tick();
        push(7'd9, 128'd2, 3'd1);
        tick();
        in_valid       = 1'b0;
        src_address[0] = 7'd9;
        src_check      = 3'b001;
        #1;
        n_checks++;
        if (fwd_hit !== 3'b001 || fwd_value[0] !== 128'd2 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL youngest_match: hit=%b value=%0d stall=%b expected 001 2 0", fwd_hit, fwd_value[0], stall);
        end
        push(7'd9, 128'd3, 3'd6);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (stall !== 1'b1 || fwd_hit !== 3'b000) begin
            n_fail++;
            $display("FAIL youngest_pending: stall=%b hit=%b expected 1 000", stall, fwd_hit);
        end
        for (int c = 4; c <= 10; c++) begin
            tick();
            n_checks++;
            if (wb_en !== (c >= 7 && c <= 9)) begin
                n_fail++;
                $display("FAIL b2b_wb_en cycle %0d: wb_en=%b", c, wb_en);
            end
            if (c >= 7 && c <= 9) begin
                n_checks++;
                if (wb_rt_address !== 7'd9 || wb_value !== 128'(c - 6)) begin
                    n_fail++;
                    $display("FAIL b2b_wb_order cycle %0d: rt=%0d value=%0d expected 9 %0d", c, wb_rt_address, wb_value, c - 6);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_still_pending: stall=%b expected 1", stall);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (stall !== 1'b0 || fwd_hit !== 3'b001 || fwd_value[0] !== 128'd3) begin
                    n_fail++;
                    $display("FAIL b2b_late_complete: stall=%b hit=%b value=%0d expected 0 001 3", stall, fwd_hit, fwd_value[0]);
                end
            end
            if (c == 10) begin
                n_checks++;
                if (fwd_hit !== 3'b000 || stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_drained: hit=%b stall=%b expected 000 0", fwd_hit, stall);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [127:0] seen;
        seen = '0;
        clear_pipe();
        for (int r = 1; r <= 4; r++) begin
            push(7'(r), 128'(100 + r), 3'd1);
            tick();
        end
        push(7'd7, 128'd107, 3'd1);
        flush = 1'b1;
        tick();
        idle();
        src_address[0] = 7'd7;
        src_address[1] = 7'd4;
        src_address[2] = 7'd1;
        src_check      = 3'b111;
        #1;
        n_checks++;
        if (fwd_hit !== 3'b100 || fwd_value[2] !== 128'd101) begin
            n_fail++;
            $display("FAIL flush_lookup: hit=%b value2=%0d expected 100 101", fwd_hit, fwd_value[2]);
        end
        src_check = 3'b000;
        for (int c = 0; c < 10; c++) begin
            if (wb_en) seen[wb_rt_address] = 1'b1;
            tick();
        end
        n_checks++;
        if (seen[1] !== 1'b1 || seen[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_survivors: rt1=%b rt2=%b expected 1 1", seen[1], seen[2]);
        end
        n_checks++;
        if (seen[4] !== 1'b0 || seen[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_squashed: rt4=%b rt7=%b expected 0 0", seen[4], seen[7]);
        end
    endtask

    task automatic test_boundary();
        clear_pipe();
        push(7'd0, 128'h5, 3'd0);
        tick();
        in_valid       = 1'b0;
        src_address[0] = 7'd0;
        src_check      = 3'b001;
        #1;
        n_checks++;
        if (fwd_hit !== 3'b001 || fwd_value[0] !== 128'h5 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rt0_lat0_fwd: hit=%b value=%h stall=%b expected 001 5 0", fwd_hit, fwd_value[0], stall);
        end
        push(7'd40, 128'hDEAD, 3'd7);
        tick();
        in_valid       = 1'b0;
        src_address[1] = 7'd40;
        src_check      = 3'b010;
        repeat (5) tick();
        n_checks++;
        if (stall !== 1'b1 || fwd_hit !== 3'b000) begin
            n_fail++;
            $display("FAIL lat7_stage6: stall=%b hit=%b expected 1 000", stall, fwd_hit);
        end
        tick();
        n_checks++;
        if (stall !== 1'b0 || fwd_hit !== 3'b010 || fwd_value[1] !== 128'hDEAD ||
            wb_en !== 1'b1 || wb_rt_address !== 7'd40) begin
            n_fail++;
            $display("FAIL lat7_stage7: stall=%b hit=%b value=%h wb_en=%b rt=%0d expected 0 010 dead 1 40",
                     stall, fwd_hit, fwd_value[1], wb_en, wb_rt_address);
        end
    endtask

`ifdef ODD_RESULT_FWD_STATS_EN
    task automatic test_stats();
        clear_pipe();
        push(7'd10, 128'd10, 3'd1);
        tick();
        in_valid    = 1'b0;
        src_address = {7'd10, 7'd10, 7'd10};
        src_check   = 3'b111;
        repeat (2) tick();
        src_check = 3'b000;
        push(7'd11, 128'd11, 3'd7);
        tick();
        in_valid       = 1'b0;
        src_address[0] = 7'd11;
        src_check      = 3'b001;
        tick();
        src_check = 3'b000;
        tick();
        n_checks++;
        if (stat_fwd_count !== 32'd6 || stat_stall_count !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_counts: fwd=%0d stall=%0d expected 6 1", stat_fwd_count, stat_stall_count);
        end
    endtask
`endif

    initial begin
        idle();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        test_reset();
        test_fixed_wb();
        test_stall_forward();
        test_back_to_back();
        test_flush();
        test_boundary();
`ifdef ODD_RESULT_FWD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
